// File: rtl/bit_count_pkg.sv
// Shared types and helpers for the bit_count_unit shift-and-add population counter.
package bit_count_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bits needed to hold any count from 0 to width inclusive.
  function automatic int res_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_count_ctrl.sv
// Control FSM for bit_count_unit: sequences load, shift-until-zero and the done handshake.
import bit_count_pkg::*;

module bit_count_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic a_zero,
  output logic load,
  output logic shift_en,
  output logic busy,
  output logic done
);

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (a_zero) state_d  = S_DONE;
        else        shift_en = 1'b1;
      end
      S_DONE: begin
        // A held request must drop before the next operand can be loaded.
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_COUNT);
  assign done = (state_q == S_DONE);

endmodule

// File: rtl/bit_count_unit.sv
// Counts ones (mode=0) or zeros (mode=1) of a WIDTH-bit operand, stopping early once the shifted operand is zero.
// Optional parity output enabled by defining BITCNT_PARITY_EN.
import bit_count_pkg::*;

module bit_count_unit #(
  parameter int WIDTH = 8,
  localparam int RES_W = bit_count_pkg::res_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result
`ifdef BITCNT_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             load, shift_en, a_zero;

  assign a_zero = (a_q == '0);

  bit_count_ctrl u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a_zero   (a_zero),
    .load     (load),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done)
  );

  // Counting zeros is counting ones of the inverted operand.
  always_comb begin
    a_d      = a_q;
    result_d = result_q;
    if (load) begin
      a_d      = mode ? ~data_in : data_in;
      result_d = '0;
    end else if (shift_en) begin
      a_d      = a_q >> 1;
      result_d = result_q + {{(RES_W-1){1'b0}}, a_q[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

`ifdef BITCNT_PARITY_EN
  assign parity = result_q[0];
`endif

endmodule

// File: tb/tb_bit_count_unit.sv
// Self-checking bench for bit_count_unit (WIDTH=8) against a popcount/latency reference model.
module tb_bit_count_unit;

  localparam int WIDTH = 8;
  localparam int RES_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset, start, mode;
  logic [WIDTH-1:0] data_in;
  logic             busy, done;
  logic [RES_W-1:0] result;
`ifdef BITCNT_PARITY_EN
  logic             parity;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_count_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .result  (result)
`ifdef BITCNT_PARITY_EN
    ,
    .parity  (parity)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input logic [WIDTH-1:0] d, input logic m);
    int c = 0;
    for (int i = 0; i < WIDTH; i++) if ((m ? !d[i] : d[i])) c++;
    return c;
  endfunction

  // Edges after the sampling edge until done: highest set index + 2, or 1 for an all-zero operand.
  function automatic int ref_lat(input logic [WIDTH-1:0] d, input logic m);
    int hi = -1;
    for (int i = 0; i < WIDTH; i++) if ((m ? !d[i] : d[i])) hi = i;
    return (hi < 0) ? 1 : hi + 2;
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] d, input logic m,
                        input bit hold, input bit tweak, input int exp_par);
    int n;
    int exp_res;
    exp_res = ref_count(d, m);
    start = 1'b1; data_in = d; mode = m;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    if (tweak) begin data_in = ~d; mode = ~m; end
    n = 0;
    while (!done && n < 40) begin
      chk("busy_during_count", busy, 1);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, ref_lat(d, m));
    chk("result", result, exp_res);
    chk("busy_in_done", busy, 0);
`ifdef BITCNT_PARITY_EN
    if (exp_par >= 0) chk("parity", parity, exp_par);
    chk("parity_eq_lsb", parity, exp_res % 2);
`endif
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      chk("done_held", done, 1);
      chk("result_held", result, exp_res);
    end
    start = 1'b0; data_in = '0; mode = 1'b0;
    @(posedge clk); #1;
    chk("done_cleared", done, 0);
    chk("idle_not_busy", busy, 0);
    chk("result_kept_idle", result, exp_res);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(8'h24, 1'b0, 0, 0, -1);
    run_op(8'h24, 1'b1, 0, 0, -1);
    run_op(8'h00, 1'b0, 0, 0, -1);
    run_op(8'hFF, 1'b0, 0, 0, -1);
    run_op(8'hFF, 1'b1, 0, 0, -1);
    run_op(8'h81, 1'b0, 1, 1, -1);

    // Reset in the middle of a count abandons it.
    start = 1'b1; data_in = 8'hF0; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_before_rst", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", busy | done, 0);
    run_op(8'h0F, 1'b0, 0, 0, -1);

    run_op(8'h07, 1'b0, 0, 0, 1);
    run_op(8'h03, 1'b0, 0, 0, 0);

    for (int i = 0; i < 40; i++)
      run_op(WIDTH'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0),
             bit'($urandom), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_count_unit.md
Name: bit_count_unit

Overview:
- Parametrised successor to the lab's single-width bit counter: counts the 1s (or 0s) in a WIDTH-bit operand with a shift-and-add datapath under FSM control.
- Uses a start/done handshake and terminates early once the shifted operand reaches zero.
- Sits behind switch/button inputs or a host FSM; the result drives a display or downstream logic.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).
- RES_W, $clog2(WIDTH+1), result width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in S_IDLE.
- mode  input  1  0 = count ones, 1 = count zeros; sampled with start.
- data_in  input  WIDTH  operand; sampled with start.
- busy  output  1  high in S_COUNT.
- done  output  1  high in S_DONE.
- result  output  RES_W  count; valid whenever done = 1.
- parity  output  1  present only under BITCNT_PARITY_EN.

Behaviour:
- Reset: state = S_IDLE, shift register A = 0, result = 0, busy = 0, done = 0. Reset overrides start and applies mid-operation, abandoning any count in progress.
- Outputs busy and done decode directly from the state register.
- S_IDLE:
  - If start = 1: load A = mode ? ~data_in : data_in, clear result to 0, go to S_COUNT.
  - Otherwise hold all registers; result keeps its last value.
- S_COUNT, each cycle:
  - If A == 0: go to S_DONE; no add this cycle.
  - Else: result <= result + A[0]; A <= A >> 1 (logical shift, zero-fill); stay in S_COUNT.
- S_DONE:
  - Hold result.
  - If start = 1: stay in S_DONE (a held request does not retrigger).
  - If start = 0: go to S_IDLE.
- Latency, counting the edge that samples start as edge 0:
  - done is high after edge k+1, where k = (index of the highest 1 in the loaded A) + 1.
  - A loaded operand of 0 gives done after edge 1 with result 0.
  - Worst case is all-ones: done after edge WIDTH+1.
- Width rule: result never overflows, since the maximum count WIDTH fits in RES_W bits. The addition is zero-extended from 1 bit.
- start, mode and data_in are ignored outside S_IDLE. Changing data_in mid-count has no effect.
- Back-to-back operation: after done, start must be low for at least one cycle (S_DONE -> S_IDLE) before the next load.

Optional Feature:
- Macro: BITCNT_PARITY_EN.
- Defined: the parity port exists and equals result[0] (odd count = 1). It is valid when done = 1 and reset to 0.
- Undefined: the parity port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package bit_count_pkg holds the state enum typedef (S_IDLE, S_COUNT, S_DONE, 2-bit encoding) and a function computing RES_W from WIDTH.
- One sub-module: bit_count_ctrl, the FSM. It takes start and a_zero, and emits load, shift_en, busy and done. Datapath registers (A, result) stay in bit_count_unit.

Test Plan (WIDTH = 8):
- Reset held 2 cycles, then mode = 0, data_in = 8'b0010_0100, start pulsed -> busy for 7 cycles, done after edge 7, result = 2.
- mode = 1, data_in = 8'h24 -> loaded A = 8'hDB; done after edge 9, result = 6.
- data_in = 8'h00, mode = 0 -> done after edge 1, result = 0. Then data_in = 8'hFF -> done after edge 9, result = 8 (max, no overflow).
- start held high throughout a count of 8'h81 -> result = 2; stays in S_DONE until start drops; change data_in during the count -> result unaffected.
- Assert reset during S_COUNT of 8'hF0 -> next cycle busy = 0, done = 0, result = 0, state = S_IDLE. A fresh start of 8'h0F -> result = 4.
- With BITCNT_PARITY_EN defined: 8'h07 -> result = 3, parity = 1. Then 8'h03 -> result = 2, parity = 0.
